// File: rtl/ring_monitor.sv
// Watches an upstream ring counter: locks onto a one-hot rotation, flags broken
// samples, counts completed revolutions and (saturating) error pulses.
module ring_monitor #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned REV_W = 8,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] count,
  input  logic             mod,
  input  logic             load,
  output logic             locked,
  output logic             onehot_err,
  output logic             step_err,
  output logic             fault,
  output logic [REV_W-1:0] rev_count,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic               locked_q, locked_d;
  logic               onehot_err_q, onehot_err_d;
  logic               step_err_q, step_err_d;
  logic               fault_q, fault_d;
  logic [REV_W-1:0]   rev_q, rev_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic               is_onehot_c;
  logic [WIDTH-1:0]   expected_c;

  // Sample classification and expected next ring position
  always_comb begin
    is_onehot_c = (count != '0) && ((count & (count - WIDTH'(1))) == '0);
    expected_c  = mod ? {prev_q[WIDTH-2:0], prev_q[WIDTH-1]}
                      : {prev_q[0], prev_q[WIDTH-1:1]};
  end

  // Next-state, tracking and counter logic
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    onehot_err_d = 1'b0;
    step_err_d   = 1'b0;
    rev_d        = rev_q;
    err_d        = err_q;

    if (sample_valid) begin
      if (!is_onehot_c) begin
        // Non-one-hot wins over load; FAULT absorbs it silently
        unique case (state_q)
          IDLE:    onehot_err_d = 1'b1;
          SYNC: begin
            state_d      = IDLE;
            onehot_err_d = 1'b1;
          end
          TRACK: begin
            state_d      = FAULT;
            onehot_err_d = 1'b1;
          end
          default: state_d = FAULT;
        endcase
      end else begin
        unique case (state_q)
          IDLE: begin
            state_d = SYNC;
            prev_d  = count;
          end
          SYNC: begin
            prev_d = count;
            if (!load && (count == expected_c)) state_d = TRACK;
          end
          TRACK: begin
            if (load) begin
              state_d = SYNC;
              prev_d  = count;
            end else if (count == expected_c) begin
              prev_d = count;
              if (count == WIDTH'(1)) rev_d = rev_q + REV_W'(1);
            end else begin
              state_d    = FAULT;
              step_err_d = 1'b1;
            end
          end
          default: begin
            if (load) begin
              state_d = SYNC;
              prev_d  = count;
            end
          end
        endcase
      end
    end

    if ((onehot_err_d || step_err_d) && (err_q != '1)) err_d = err_q + ERR_W'(1);

    locked_d = (state_d == TRACK);
    fault_d  = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      locked_q     <= 1'b0;
      onehot_err_q <= 1'b0;
      step_err_q   <= 1'b0;
      fault_q      <= 1'b0;
      rev_q        <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      locked_q     <= locked_d;
      onehot_err_q <= onehot_err_d;
      step_err_q   <= step_err_d;
      fault_q      <= fault_d;
      rev_q        <= rev_d;
      err_q        <= err_d;
    end
  end

  assign locked     = locked_q;
  assign onehot_err = onehot_err_q;
  assign step_err   = step_err_q;
  assign fault      = fault_q;
  assign rev_count  = rev_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_ring_monitor.sv
// Directed bench for ring_monitor: lock, revolutions, faults, saturation, reset.
module tb_ring_monitor;

  logic       clk;
  logic       reset;
  logic       sample_valid;
  logic [3:0] count;
  logic       mod;
  logic       load;
  logic       locked;
  logic       onehot_err;
  logic       step_err;
  logic       fault;
  logic [7:0] rev_count;
  logic [7:0] err_count;

  int errors = 0;
  int checks = 0;

  ring_monitor #(.WIDTH(4), .REV_W(8), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .count(count),
    .mod(mod), .load(load), .locked(locked), .onehot_err(onehot_err),
    .step_err(step_err), .fault(fault), .rev_count(rev_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic smp(input logic [3:0] c, input logic m, input logic ld);
    sample_valid = 1'b1;
    count        = c;
    mod          = m;
    load         = ld;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_oh"}, 32'(onehot_err), 32'd0);
    check({tag, "_st"}, 32'(step_err), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_rev"}, 32'(rev_count), 32'd0);
    check({tag, "_err"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    reset = 1'b0; sample_valid = 1'b1; count = 4'b0011; mod = 1'b1; load = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all_zero("reset");
    reset = 1'b1;

    // Acquire lock
    smp(4'b0001, 1'b1, 1'b0);
    check("sync_locked", 32'(locked), 32'd0);
    smp(4'b0010, 1'b1, 1'b0);
    check("lock_locked", 32'(locked), 32'd1);
    check("lock_rev", 32'(rev_count), 32'd0);
    idle_cycle();
    check("hold_locked", 32'(locked), 32'd1);
    check("hold_oh", 32'(onehot_err), 32'd0);

    // One revolution rotating left
    smp(4'b0100, 1'b1, 1'b0);
    smp(4'b1000, 1'b1, 1'b0);
    check("rev_before", 32'(rev_count), 32'd0);
    smp(4'b0001, 1'b1, 1'b0);
    check("rev_after", 32'(rev_count), 32'd1);
    check("rev_err", 32'(err_count), 32'd0);

    // Bad step from 0100
    smp(4'b0010, 1'b1, 1'b0);
    smp(4'b0100, 1'b1, 1'b0);
    smp(4'b0001, 1'b1, 1'b0);
    check("step_st", 32'(step_err), 32'd1);
    check("step_oh", 32'(onehot_err), 32'd0);
    check("step_fault", 32'(fault), 32'd1);
    check("step_locked", 32'(locked), 32'd0);
    check("step_err_cnt", 32'(err_count), 32'd1);
    smp(4'b0010, 1'b1, 1'b0);
    check("fault_hold_st", 32'(step_err), 32'd0);
    check("fault_hold", 32'(fault), 32'd1);
    check("fault_hold_cnt", 32'(err_count), 32'd1);

    // Recover with load, relock rotating right
    smp(4'b1000, 1'b1, 1'b1);
    check("recover_fault", 32'(fault), 32'd0);
    check("recover_locked", 32'(locked), 32'd0);
    smp(4'b0100, 1'b0, 1'b0);
    check("relock", 32'(locked), 32'd1);

    // Direction changes and right-rotate revolution
    smp(4'b1000, 1'b1, 1'b0);
    check("dir_left", 32'(locked), 32'd1);
    smp(4'b0100, 1'b0, 1'b0);
    smp(4'b0010, 1'b0, 1'b0);
    smp(4'b0001, 1'b0, 1'b0);
    check("rev_right", 32'(rev_count), 32'd2);
    smp(4'b1000, 1'b0, 1'b0);
    check("wrap_right", 32'(locked), 32'd1);
    check("dir_err", 32'(err_count), 32'd1);

    // Non-one-hot with load takes precedence
    smp(4'b0110, 1'b1, 1'b1);
    check("ohload_oh", 32'(onehot_err), 32'd1);
    check("ohload_st", 32'(step_err), 32'd0);
    check("ohload_fault", 32'(fault), 32'd1);
    check("ohload_cnt", 32'(err_count), 32'd2);
    smp(4'b0000, 1'b1, 1'b0);
    check("fault_quiet_oh", 32'(onehot_err), 32'd0);
    check("fault_quiet_cnt", 32'(err_count), 32'd2);
    smp(4'b0001, 1'b1, 1'b1);
    smp(4'b0000, 1'b1, 1'b0);
    check("sync_drop_oh", 32'(onehot_err), 32'd1);
    check("sync_drop_cnt", 32'(err_count), 32'd3);
    for (int i = 0; i < 300; i++) smp(4'b0000, 1'b1, 1'b0);
    check("sat_cnt", 32'(err_count), 32'd255);
    check("sat_oh", 32'(onehot_err), 32'd1);
    check("sat_locked", 32'(locked), 32'd0);
    check("sat_fault", 32'(fault), 32'd0);
    idle_cycle();
    check("sat_idle_oh", 32'(onehot_err), 32'd0);

    // Reset from FAULT, then five revolutions
    smp(4'b0001, 1'b1, 1'b0);
    smp(4'b0010, 1'b1, 1'b0);
    smp(4'b0011, 1'b1, 1'b0);
    check("pre_reset_fault", 32'(fault), 32'd1);
    reset = 1'b0; @(posedge clk); #1; reset = 1'b1;
    check_all_zero("fault_reset");
    smp(4'b0001, 1'b1, 1'b0);
    smp(4'b0010, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      smp(4'b0100, 1'b1, 1'b0);
      smp(4'b1000, 1'b1, 1'b0);
      smp(4'b0001, 1'b1, 1'b0);
      smp(4'b0010, 1'b1, 1'b0);
    end
    check("rev5", 32'(rev_count), 32'd5);
    check("rev5_locked", 32'(locked), 32'd1);

    // Reset for one edge with a valid sample present
    reset = 1'b0; sample_valid = 1'b1; count = 4'b0100; mod = 1'b1; load = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; sample_valid = 1'b0;
    check_all_zero("lock_reset");
    smp(4'b0011, 1'b1, 1'b0);
    check("post_reset_oh", 32'(onehot_err), 32'd1);
    check("post_reset_locked", 32'(locked), 32'd0);
    check("post_reset_fault", 32'(fault), 32'd0);
    check("post_reset_cnt", 32'(err_count), 32'd1);
    smp(4'b0001, 1'b1, 1'b0);
    check("post_reset_sync", 32'(locked), 32'd0);
    smp(4'b0010, 1'b1, 1'b0);
    check("post_reset_lock", 32'(locked), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
